// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter and instruction fetch stage with stall, redirect, halt and program load
module fetch_unit #(
   parameter int                    PC_WIDTH   = 8,
   parameter int                    INST_WIDTH = 32,
   parameter int                    DEPTH      = 256,
   parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect_en,
   input  logic                  redirect_mode,
   input  logic [PC_WIDTH-1:0]   redirect_target,
   input  logic                  halt,
   input  logic                  prog_we,
   input  logic [PC_WIDTH-1:0]   prog_addr,
   input  logic [INST_WIDTH-1:0] prog_data,
   output logic [PC_WIDTH-1:0]   pc,
   output logic [INST_WIDTH-1:0] inst,
   output logic [PC_WIDTH-1:0]   inst_pc,
   output logic                  inst_valid,
   output logic                  halted,
   output logic                  fetch_fault
);

   localparam logic [PC_WIDTH:0] DEPTH_LIM = (PC_WIDTH + 1)'(DEPTH);

   logic [INST_WIDTH-1:0] mem [0:DEPTH-1];

   logic                  pc_in_range;
   logic                  prog_in_range;
   logic [PC_WIDTH-1:0]   redirect_pc;

   assign pc_in_range   = {1'b0, pc} < DEPTH_LIM;
   assign prog_in_range = {1'b0, prog_addr} < DEPTH_LIM;
   assign redirect_pc   = redirect_mode ? (inst_pc + redirect_target) : redirect_target;

   // Program load is not gated by reset, stall or halt; contents survive reset.
   always_ff @(posedge clk) begin
      if (prog_we && prog_in_range) begin
         mem[prog_addr] <= prog_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         inst        <= '0;
         inst_pc     <= '0;
         inst_valid  <= 1'b0;
         halted      <= 1'b0;
         fetch_fault <= 1'b0;
      end else if (halted || halt) begin
         halted     <= 1'b1;
         inst_valid <= 1'b0;
      end else if (stall) begin
         pc <= pc;
      end else if (redirect_en) begin
         // Squash the word fetched from the old pc; inst_pc keeps the branch origin.
         pc         <= redirect_pc;
         inst_valid <= 1'b0;
      end else begin
         inst_pc     <= pc;
         inst_valid  <= 1'b1;
         pc          <= pc + 1'b1;
         if (pc_in_range) begin
            inst        <= mem[pc];
            fetch_fault <= 1'b0;
         end else begin
            inst        <= '0;
            fetch_fault <= 1'b1;
         end
      end
   end

endmodule
